dmem_responder: RTL and testbench

- Data-memory responder: the memory end of the core's load/store request interface (MemEn, WriteByteEn, address, write data).
- Accepts one request at a time and models a fixed access latency.
- Writes byte-enabled words into a local array and returns read data with a response strobe.
- Provides a Stall signal so the core holds its load/store instruction until RspValid.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_bytewise_ram.sv | 28 ++
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;

  typedef struct packed {
    logic [31:0]           addr;
    logic [WORD_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] byteen;
  } req_t;

  // Misaligned, or word index beyond the 2**addr_w words of the array.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_bytewise_ram.sv
// Word-organised RAM with per-byte write enables; synchronous write,
// combinational read.
module dmem_bytewise_ram
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic [WORD_BYTES-1:0] we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core load/store interface: one request at a time,
// fixed access latency, byte-enabled writes, registered read data/fault.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemEn,
  input  logic [3:0]  WriteByteEn,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        ReqReady,
  output logic        RspValid,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic        Stall
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;

  req_t                  req_in;
  req_t                  acc_req;
  logic                  access;
  logic                  acc_fault;
  logic [WORD_BYTES-1:0] ram_we;
  logic [WORD_W-1:0]     ram_rdata;

  assign req_in = '{addr: Addr, wdata: WriteData, byteen: WriteByteEn};

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // live inputs are used instead of the not-yet-latched request.
  assign acc_req   = (state_q == IDLE) ? req_in : req_q;
  assign acc_fault = addr_fault(acc_req.addr, ADDR_W);

  // cnt_q holds the edges remaining before the access; the access edge is
  // the one on which it would reach 0.
  assign access = ((state_q == WAIT) && (cnt_q == 4'd1)) ||
                  ((state_q == IDLE) && MemEn && (LATENCY == 1));

  assign ram_we = (access && !acc_fault) ? acc_req.byteen : '0;

  dmem_bytewise_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (acc_req.addr[ADDR_W+1:2]),
    .wdata_i (acc_req.wdata),
    .rdata_o (ram_rdata)
  );

  // Request FSM, latency counter and access result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (MemEn) begin
          req_d   = req_in;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (access) begin
      fault_d = acc_fault;
      rdata_d = (!acc_fault && (acc_req.byteen == '0)) ? ram_rdata : '0;
    end
  end

  // State registers; a pending request is simply dropped on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign ReqReady = (state_q == IDLE);
  assign RspValid = (state_q == RESP);
  assign ReadData = rdata_q;
  assign Fault    = fault_q;
  assign Stall    = MemEn & ~RspValid;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level reference model.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemEn;
  logic [3:0]  WriteByteEn;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        ReqReady;
  logic        RspValid;
  logic [31:0] ReadData;
  logic        Fault;
  logic        Stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .MemEn       (MemEn),
    .WriteByteEn (WriteByteEn),
    .Addr        (Addr),
    .WriteData   (WriteData),
    .ReqReady    (ReqReady),
    .RspValid    (RspValid),
    .ReadData    (ReadData),
    .Fault       (Fault),
    .Stall       (Stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing by edge arithmetic: accept at edge e when free, response visible
  // after edge e+LAT-1, next accept possible at edge e+LAT+1.
  int          edge_n     = 0;
  int          free_edge  = 0;
  bit          pend       = 0;
  int          pend_edge  = 0;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_be;
  int          rsp_edge   = -1;
  logic [31:0] exp_rd     = '0;
  logic        exp_fault  = 1'b0;
  int          rsp_count  = 0;
  int          acc_count  = 0;
  logic [31:0] mm [int unsigned];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      = 0;
      free_edge = 0;
      rsp_edge  = -1;
      exp_rd    = '0;
      exp_fault = 1'b0;
    end else begin
      edge_n++;
      if (MemEn && edge_n >= free_edge) begin
        pend      = 1;
        p_addr    = Addr;
        p_wd      = WriteData;
        p_be      = WriteByteEn;
        pend_edge = edge_n + int'(LAT) - 1;
        free_edge = pend_edge + 2;
        acc_count++;
      end
      if (pend && edge_n == pend_edge) begin
        int unsigned idx;
        logic [31:0] w;
        pend      = 0;
        idx       = p_addr / 4;
        exp_fault = ((p_addr % 4) != 0) || (idx >= DEPTH);
        exp_rd    = '0;
        if (!exp_fault) begin
          w = mm.exists(idx) ? mm[idx] : '0;
          if (p_be != 4'b0000) begin
            for (int b = 0; b < 4; b++)
              if (p_be[b]) w[8*b +: 8] = p_wd[8*b +: 8];
            mm[idx] = w;
          end else begin
            exp_rd = w;
          end
        end
        rsp_edge = edge_n;
        rsp_count++;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      bit er;
      er = (rsp_edge == edge_n);
      chk("RspValid", 32'(RspValid), 32'(er));
      chk("ReqReady", 32'(ReqReady), 32'(edge_n + 1 >= free_edge));
      chk("Stall", 32'(Stall), 32'(MemEn & ~er));
      if (er) begin
        chk("ReadData", ReadData, exp_rd);
        chk("Fault", 32'(Fault), 32'(exp_fault));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic flt, output logic st);
    int start;
    bit got;
    start = rsp_count;
    got   = 0;
    rd    = '0;
    flt   = 1'b0;
    st    = 1'b1;
    @(negedge clk);
    Addr = a; WriteData = wd; WriteByteEn = be; MemEn = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (rsp_count != start) begin
        got = 1;
        rd  = ReadData;
        flt = Fault;
        st  = Stall;
        chk("rsp_strobe", 32'(RspValid), 32'd1);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout: no response for addr 0x%08h (got none, required one)", a);
    end
    @(negedge clk);
    MemEn = 1'b0;
  endtask

  logic [31:0] rd;
  logic        flt, st;
  int          pulse_edges[$];

  initial begin
    reset_n = 1'b0; MemEn = 1'b0; WriteByteEn = '0; Addr = '0; WriteData = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ReqReady", 32'(ReqReady), 32'd1);
    chk("rst_RspValid", 32'(RspValid), 32'd0);
    chk("rst_ReadData", ReadData, 32'd0);
    chk("rst_Fault", 32'(Fault), 32'd0);
    chk("rst_Stall", 32'(Stall), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_req(32'h10, 32'hDEADBEEF, 4'hF, rd, flt, st);
    chk("st10_fault", 32'(flt), 32'd0);
    chk("st10_stall_rsp", 32'(st), 32'd0);
    do_req(32'h0, 32'h0BADF00D, 4'hF, rd, flt, st);
    do_req(32'h10, 32'h0, 4'h0, rd, flt, st);
    chk("ld10", rd, 32'hDEADBEEF);
    do_req(32'h10, 32'h0000AA00, 4'b0010, rd, flt, st);
    do_req(32'h10, 32'h0, 4'h0, rd, flt, st);
    chk("ld10_partial", rd, 32'hDEADAAEF);
    chk("model_pin_10", mm[32'h4], 32'hDEADAAEF);

    do_req(32'h12, 32'h0, 4'h0, rd, flt, st);
    chk("misalign_fault", 32'(flt), 32'd1);
    chk("misalign_rd", rd, 32'd0);
    do_req(32'(4 * DEPTH), 32'h0, 4'h0, rd, flt, st);
    chk("oor_ld_fault", 32'(flt), 32'd1);
    do_req(32'(4 * DEPTH), 32'h55555555, 4'hF, rd, flt, st);
    chk("oor_st_fault", 32'(flt), 32'd1);
    do_req(32'h0, 32'h0, 4'h0, rd, flt, st);
    chk("ld0_after_oor", rd, 32'h0BADF00D);
    do_req(32'h10, 32'h0, 4'h0, rd, flt, st);
    chk("ld10_after_oor", rd, 32'hDEADAAEF);

    // MemEn held high across three loads
    @(negedge clk);
    begin
      int a0;
      a0 = acc_count;
      Addr = 32'h10; WriteByteEn = 4'h0; MemEn = 1'b1;
      for (int i = 0; i < 3 * int'(LAT + 1) + 4; i++) begin
        @(negedge clk);
        #1;
        if (RspValid) pulse_edges.push_back(edge_n);
        if (acc_count - a0 == 3) MemEn = 1'b0;
      end
      MemEn = 1'b0;
    end
    chk("hold_pulses", 32'(pulse_edges.size()), 32'd3);
    if (pulse_edges.size() == 3) begin
      chk("hold_gap1", 32'(pulse_edges[1] - pulse_edges[0]), 32'(LAT + 1));
      chk("hold_gap2", 32'(pulse_edges[2] - pulse_edges[1]), 32'(LAT + 1));
    end

    // Reset in the middle of a store's wait period
    do_req(32'h20, 32'h11223344, 4'hF, rd, flt, st);
    do_req(32'h20, 32'h0, 4'h0, rd, flt, st);
    chk("ld20", rd, 32'h11223344);
    @(negedge clk);
    Addr = 32'h20; WriteData = 32'hCAFEF00D; WriteByteEn = 4'hF; MemEn = 1'b1;
    @(posedge clk);
    #1;
    chk("wait_ReqReady", 32'(ReqReady), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ReqReady", 32'(ReqReady), 32'd1);
    chk("mid_rst_RspValid", 32'(RspValid), 32'd0);
    chk("mid_rst_ReadData", ReadData, 32'd0);
    chk("mid_rst_Fault", 32'(Fault), 32'd0);
    MemEn = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_req(32'h20, 32'h0, 4'h0, rd, flt, st);
    chk("ld20_after_rst", rd, 32'h11223344);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
